// File: rtl/writeback_regfile.sv
// Writeback stage: result select, R0-R14 register file commit, Decode read ports
// with R15 = PC+8 and same-cycle bypass, PC redirect, and retired-write counter.
module writeback_regfile #(
  parameter int DATA_W = 32,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemtoRegW,
  input  logic              RegWriteW,
  input  logic              PCSrcW,
  input  logic [3:0]        WA3W,
  input  logic [DATA_W-1:0] ALUResultW,
  input  logic [DATA_W-1:0] RDataW,
  input  logic [3:0]        RA1D,
  input  logic [3:0]        RA2D,
  input  logic [DATA_W-1:0] PCPlus8D,
  output logic [DATA_W-1:0] RD1D,
  output logic [DATA_W-1:0] RD2D,
  output logic [DATA_W-1:0] ResultW,
  output logic              PCRedirW,
  output logic [DATA_W-1:0] PCTargetW,
  output logic [31:0]       RetCntW
);

  localparam logic [3:0] PC_IDX   = 4'hF;
  localparam int         NUM_REGS = 15;

  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];
  logic [31:0]       ret_cnt_q, ret_cnt_d;
  logic              wr_en;

  assign ResultW   = MemtoRegW ? RDataW : ALUResultW;
  assign wr_en     = RegWriteW && (WA3W != PC_IDX);
  assign PCRedirW  = PCSrcW;
  assign PCTargetW = ResultW;
  assign RetCntW   = ret_cnt_q;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      rf_d[i] = rf_q[i];
      if (wr_en && (WA3W == 4'(i))) rf_d[i] = ResultW;
    end
  end

  // A branch that also writes a GPR retires once, not twice.
  always_comb begin
    ret_cnt_d = ret_cnt_q;
    if (wr_en || PCSrcW) ret_cnt_d = ret_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      ret_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= rf_d[i];
      ret_cnt_q <= ret_cnt_d;
    end
  end

  always_comb begin
    RD1D = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (RA1D == 4'(i)) RD1D = rf_q[i];
    end
    if ((BYPASS != 0) && wr_en && (WA3W == RA1D)) RD1D = ResultW;
    if (RA1D == PC_IDX) RD1D = PCPlus8D;
  end

  always_comb begin
    RD2D = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (RA2D == 4'(i)) RD2D = rf_q[i];
    end
    if ((BYPASS != 0) && wr_en && (WA3W == RA2D)) RD2D = ResultW;
    if (RA2D == PC_IDX) RD2D = PCPlus8D;
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: commit, bypass, R15 handling, async reset, counter wrap.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemtoRegW, RegWriteW, PCSrcW;
  logic [3:0]  WA3W, RA1D, RA2D;
  logic [31:0] ALUResultW, RDataW, PCPlus8D;
  logic [31:0] RD1D, RD2D, ResultW, PCTargetW, RetCntW;
  logic        PCRedirW;

  int n_checks = 0;
  int n_errors = 0;

  writeback_regfile #(.DATA_W(32), .BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .MemtoRegW(MemtoRegW), .RegWriteW(RegWriteW), .PCSrcW(PCSrcW),
    .WA3W(WA3W), .ALUResultW(ALUResultW), .RDataW(RDataW),
    .RA1D(RA1D), .RA2D(RA2D), .PCPlus8D(PCPlus8D),
    .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW),
    .PCRedirW(PCRedirW), .PCTargetW(PCTargetW), .RetCntW(RetCntW)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble_inputs();
    RegWriteW = 1'b0;
    PCSrcW    = 1'b0;
    MemtoRegW = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bubble_inputs();
    WA3W = 4'd0; ALUResultW = '0; RDataW = '0;
    RA1D = 4'd3; RA2D = 4'hF; PCPlus8D = 32'h108;
    #3;
    check("rst_rd1", RD1D, 32'h0);
    check("rst_rd2_pc", RD2D, 32'h108);
    check("rst_cnt", RetCntW, 32'h0);
    tick(); tick();
    rst = 1'b0;

    // ALU commit to R2
    RegWriteW = 1'b1; WA3W = 4'd2; ALUResultW = 32'hDEADBEEF; RDataW = 32'h1111; RA1D = 4'd2;
    #1;
    check("alu_result", ResultW, 32'hDEADBEEF);
    tick();
    bubble_inputs(); RA2D = 4'd2;
    #1;
    check("alu_commit_rd1", RD1D, 32'hDEADBEEF);
    check("alu_commit_rd2", RD2D, 32'hDEADBEEF);
    check("alu_cnt", RetCntW, 32'd1);

    // load into R5 with bypass on both ports
    RegWriteW = 1'b1; MemtoRegW = 1'b1; RDataW = 32'h55AA; ALUResultW = 32'h1234;
    WA3W = 4'd5; RA1D = 4'd5; RA2D = 4'd5;
    #1;
    check("ld_result", ResultW, 32'h55AA);
    check("ld_bypass_rd1", RD1D, 32'h55AA);
    check("ld_bypass_rd2", RD2D, 32'h55AA);
    tick();
    bubble_inputs(); MemtoRegW = 1'b1; RDataW = 32'h777;
    #1;
    check("ld_nobypass_rd1", RD1D, 32'h55AA);
    check("ld_cnt", RetCntW, 32'd2);

    // write to R15 with redirect
    MemtoRegW = 1'b0; RegWriteW = 1'b1; PCSrcW = 1'b1; WA3W = 4'hF; ALUResultW = 32'h200;
    RA1D = 4'd2; RA2D = 4'hF;
    #1;
    check("pc_redir", {31'd0, PCRedirW}, 32'd1);
    check("pc_target", PCTargetW, 32'h200);
    check("pc_r15_read", RD2D, 32'h108);
    tick();
    bubble_inputs(); RA2D = 4'd5;
    #1;
    check("pc_cnt", RetCntW, 32'd3);
    check("pc_r2_kept", RD1D, 32'hDEADBEEF);
    check("pc_r5_kept", RD2D, 32'h55AA);

    // R15 write without PCSrc: dropped, no count
    RegWriteW = 1'b1; WA3W = 4'hF; ALUResultW = 32'h300;
    #1;
    check("r15drop_redir", {31'd0, PCRedirW}, 32'd0);
    tick();
    bubble_inputs();
    #1;
    check("r15drop_cnt", RetCntW, 32'd3);

    // branch-with-link style: GPR write and PCSrc together counts once
    RegWriteW = 1'b1; PCSrcW = 1'b1; WA3W = 4'd4; ALUResultW = 32'h44; RA1D = 4'd4;
    tick();
    bubble_inputs();
    #1;
    check("both_cnt", RetCntW, 32'd4);
    check("both_r4", RD1D, 32'h44);

    // async reset mid-cycle after writing R7
    RegWriteW = 1'b1; WA3W = 4'd7; ALUResultW = 32'd9; RA1D = 4'd7; RA2D = 4'd2;
    tick();
    bubble_inputs();
    #1;
    check("r7_written", RD1D, 32'd9);
    check("r7_cnt", RetCntW, 32'd5);
    #1;
    rst = 1'b1;
    #1;
    check("arst_r7", RD1D, 32'h0);
    check("arst_r2", RD2D, 32'h0);
    check("arst_cnt", RetCntW, 32'h0);
    RegWriteW = 1'b1; WA3W = 4'd7; ALUResultW = 32'hAA;
    #1;
    check("arst_bypass", RD1D, 32'hAA);
    tick();
    bubble_inputs();
    #1;
    check("arst_nowrite", RD1D, 32'h0);
    check("arst_nocount", RetCntW, 32'h0);

    // first edge after release commits
    rst = 1'b0;
    RegWriteW = 1'b1; WA3W = 4'd3; ALUResultW = 32'h33; RA1D = 4'd3;
    tick();
    bubble_inputs();
    #1;
    check("post_rst_r3", RD1D, 32'h33);
    check("post_rst_cnt", RetCntW, 32'd1);

    // counter wrap via preload
    @(negedge clk);
    dut.ret_cnt_q = 32'hFFFF_FFFE;
    tick();
    check("wrap_bubble", RetCntW, 32'hFFFF_FFFE);
    RegWriteW = 1'b1; WA3W = 4'd1; ALUResultW = 32'h1;
    tick();
    check("wrap_max", RetCntW, 32'hFFFF_FFFF);
    tick();
    check("wrap_zero", RetCntW, 32'h0);
    bubble_inputs();
    tick(); tick();
    check("wrap_bubble_hold", RetCntW, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
